dma_block_writer: RTL and testbench
===================================

# dma_block_writer

Write-back initiator for the CNN memory interface. Captures one block of `BLOCK_SIZE` layer output words in a single cycle and streams it into the shared DMA/RAM as consecutive single-word writes. It sits between the convolution/pooling output stage and the memory port, driving the same enable/RW/address/data signals the memory block responds to. The write direction is RW = 0.

## Interface
- `ADDR_WIDTH`, default 16: memory address width.
- `DATA_WIDTH`, default 16: word width, signed fixed point.
- `BLOCK_SIZE`, default 25: words per block.
- `clk`  in  1: single clock; all activity on the rising edge.
- `rst`  in  1: synchronous, active-high reset.
- `start`  in  1: request to write a block; sampled only in IDLE.
- `base_addr`  in  ADDR_WIDTH: address of word 0; captured with `start`.
- `block_in`  in  BLOCK_SIZE*DATA_WIDTH: flattened block; word k is at bits [k*DATA_WIDTH +: DATA_WIDTH]; captured with `start`.
- `mem_wait`  in  1: memory stall; while high, the current write is not accepted.
- `mem_en`  out  1: memory enable, registered.
- `mem_rw`  out  1: constant 0 while `mem_en` = 1 (write); 1 when idle.
- `mem_addr`  out  ADDR_WIDTH: write address, registered.
- `mem_wdata`  out  DATA_WIDTH: write data, registered.
- `busy`  out  1: high from capture until the last word is accepted.
- `done`  out  1: one-cycle pulse after the last word is accepted.

## Operation
- States: IDLE, WRITE.
- IDLE, `start` = 1:
  - Latch `block_in` into an internal BLOCK_SIZE-entry buffer, latch `base_addr`, set index = 0.
  - Go to WRITE and present word 0 on the next cycle.
- IDLE, `start` = 0: outputs hold their idle values.
- WRITE:
  - Outputs are `mem_en` = 1, `mem_rw` = 0, `mem_addr` = base + index, `mem_wdata` = buffer[index].
  - A write is accepted on any edge where `mem_en` = 1 and `mem_wait` = 0. Acceptance increments the index and presents the next word.
  - Accepting index BLOCK_SIZE-1 returns to IDLE: `mem_en` drops, `busy` drops, and `done` pulses for one cycle.
- Address arithmetic is modulo 2^ADDR_WIDTH. With base = 0xFFF0, word 16 goes to 0x0000. There is no error flag.
- `start` while `busy`: ignored. Neither the buffer nor the base is disturbed.
- `start` in the cycle `done` is high: the FSM is already in IDLE, so the start is accepted (back-to-back blocks).
- `block_in` and `base_addr` may change freely after capture.

## Timing
- Reset values:
  - State IDLE, index 0.
  - `mem_en` = 0, `mem_rw` = 1, `mem_addr` = 0, `mem_wdata` = 0.
  - `busy` = 0, `done` = 0.
  - Buffer contents are don't-care.
- `start` sampled at edge E0. Word 0 is valid after E0.
- With no stalls, word k is accepted at E(k+1). `done` is high after E(BLOCK_SIZE) for exactly one cycle.
- Each stalled cycle delays all later events by one cycle. Address and data are stable throughout a stall.
- `rst` asserted at any edge, including mid-block, forces reset values after that edge. The remaining words are abandoned and no `done` is issued. `rst` has priority over `start`.
- Throughput: one word per cycle. Block period is BLOCK_SIZE+1 cycles per back-to-back block.

## Configuration
- `DMA_WB_RELU_EN`:
  - Defined: each word is rectified at capture. Negative values (MSB = 1) are stored as 0 and non-negative values pass unchanged. This fuses the ReLU activation into write-back.
  - Undefined: words are written bit-exact. The capture path has no comparator logic.

## Test plan
- Reset, then `start` with base 0x0100 and words k = 0x0400 + k (no stalls):
  - Writes 0x0100..0x0118 carry 0x0400..0x0418, accepted at E1..E25.
  - `done` pulses once after E25.
- Same block with `mem_wait` high for 3 cycles during word 10:
  - `mem_addr` holds 0x010A and `mem_wdata` holds 0x040A for the stall.
  - `done` moves to after E28.
  - No word is lost or duplicated.
- Base 0xFFF0:
  - Word 15 goes to 0xFFFF, word 16 to 0x0000, word 24 to 0x0008.
- Second `start` with different data at E5 of a block:
  - Ignored; the first block is written unchanged.
  - A `start` in the `done` cycle launches a new block, with its word 0 present on the next cycle.
- `rst` pulsed after E12:
  - All outputs return to reset values after that edge.
  - No `done` is issued, and the next `start` restarts at word 0.
- With `DMA_WB_RELU_EN`, word 3 = 0xF000 and word 4 = 0x0800:
  - 0x0000 is written for word 3 and 0x0800 for word 4.
  - Without the macro, 0xF000 is written for word 3.

Source files
------------

// File: rtl/dma_block_writer_if.sv
// dma_block_writer_if
//   Memory-port bundle between the block write-back initiator and the
//   shared DMA/RAM. The initiator drives enable/RW/address/data; the memory
//   answers with a stall.
//
//   Signals:
//     mem_en     initiator -> memory  enable for the current access
//     mem_rw     initiator -> memory  0 = write, 1 = idle/read
//     mem_addr   initiator -> memory  ADDR_WIDTH word address
//     mem_wdata  initiator -> memory  DATA_WIDTH write data
//     mem_wait   memory -> initiator  stall; the current access is held
//
//   Modports: master (initiator side), slave (memory side).
interface dma_block_writer_if #(
  parameter int ADDR_WIDTH = 16,
  parameter int DATA_WIDTH = 16
);
  logic                  mem_en;
  logic                  mem_rw;
  logic [ADDR_WIDTH-1:0] mem_addr;
  logic [DATA_WIDTH-1:0] mem_wdata;
  logic                  mem_wait;

  modport master (
    output mem_en,
    output mem_rw,
    output mem_addr,
    output mem_wdata,
    input  mem_wait
  );

  modport slave (
    input  mem_en,
    input  mem_rw,
    input  mem_addr,
    input  mem_wdata,
    output mem_wait
  );
endinterface

// File: rtl/dma_block_writer.sv
// dma_block_writer
//   Write-back initiator for the CNN memory interface. Captures one block of
//   BLOCK_SIZE layer output words in a single cycle and streams it to memory
//   as consecutive single-word writes (mem_rw = 0), one word per cycle unless
//   the memory stalls.
//
//   Ports:
//     clk        in   rising-edge clock
//     rst        in   synchronous, active-high reset
//     start      in   request to write a block (honoured only when idle)
//     base_addr  in   address of word 0, captured with start
//     block_in   in   flattened block, word k at [k*DATA_WIDTH +: DATA_WIDTH]
//     busy       out  high from capture until the last word is accepted
//     done       out  one-cycle pulse after the last word is accepted
//     mem        master modport of dma_block_writer_if (memory port)
//
//   Configuration macro:
//     DMA_WB_RELU_EN  when defined, negative words are stored as zero at
//                     capture (fused ReLU); otherwise words pass bit-exact.
module dma_block_writer #(
  parameter int ADDR_WIDTH = 16,
  parameter int DATA_WIDTH = 16,
  parameter int BLOCK_SIZE = 25
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic                             start,
  input  logic [ADDR_WIDTH-1:0]            base_addr,
  input  logic [BLOCK_SIZE*DATA_WIDTH-1:0] block_in,
  output logic                             busy,
  output logic                             done,
  dma_block_writer_if.master               mem
);

  localparam int IDX_W = (BLOCK_SIZE > 1) ? $clog2(BLOCK_SIZE) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(BLOCK_SIZE - 1);

  typedef enum logic {
    IDLE  = 1'b0,
    WRITE = 1'b1
  } state_t;

  state_t                state_q, state_d;
  logic [IDX_W-1:0]      idx_q, idx_d;
  logic [ADDR_WIDTH-1:0] base_q;
  logic [ADDR_WIDTH-1:0] base_sel;
  logic [DATA_WIDTH-1:0] buf_q    [BLOCK_SIZE];
  logic [DATA_WIDTH-1:0] cap_word [BLOCK_SIZE];

  logic                  capture;
  logic                  accept;
  logic                  done_d;
  logic [ADDR_WIDTH-1:0] addr_d;
  logic [DATA_WIDTH-1:0] wdata_d;

  logic                  en_q;
  logic                  rw_q;
  logic [ADDR_WIDTH-1:0] addr_q;
  logic [DATA_WIDTH-1:0] wdata_q;
  logic                  busy_q;
  logic                  done_q;

  // Word conditioning on the capture path: optional ReLU clamps negative
  // words to zero so the buffer only ever holds the rectified activations.
  for (genvar k = 0; k < BLOCK_SIZE; k++) begin : g_cap
`ifdef DMA_WB_RELU_EN
    assign cap_word[k] = block_in[k*DATA_WIDTH + DATA_WIDTH - 1]
                         ? '0 : block_in[k*DATA_WIDTH +: DATA_WIDTH];
`else
    assign cap_word[k] = block_in[k*DATA_WIDTH +: DATA_WIDTH];
`endif
  end

  // A word leaves the port on any edge where it is presented and not stalled.
  // While in WRITE the registered enable is always high, so the state alone
  // stands in for mem_en here.
  assign accept = (state_q == WRITE) && !mem.mem_wait;

  // Next-state logic plus the next values of the registered memory outputs.
  // Outputs are computed from the next index so that address and data are
  // already valid in the cycle right after capture or acceptance, and held
  // unchanged through a stall (index does not move).
  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    capture = 1'b0;
    done_d  = 1'b0;

    case (state_q)
      IDLE: begin
        if (start) begin
          capture = 1'b1;
          idx_d   = '0;
          state_d = WRITE;
        end
      end
      WRITE: begin
        if (accept) begin
          if (idx_q == LAST_IDX) begin
            state_d = IDLE;
            idx_d   = '0;
            done_d  = 1'b1;
          end else begin
            idx_d = idx_q + 1'b1;
          end
        end
      end
      default: begin
        state_d = IDLE;
        idx_d   = '0;
      end
    endcase

    // On the capture cycle the buffer is not yet loaded, so word 0 and the
    // base come straight from the (conditioned) inputs.
    base_sel = capture ? base_addr : base_q;
    addr_d   = '0;
    wdata_d  = '0;
    if (state_d == WRITE) begin
      addr_d  = base_sel + ADDR_WIDTH'(idx_d);
      wdata_d = capture ? cap_word[0] : buf_q[idx_d];
    end
  end

  // State, index, base and registered memory-port outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      idx_q   <= '0;
      base_q  <= '0;
      en_q    <= 1'b0;
      rw_q    <= 1'b1;
      addr_q  <= '0;
      wdata_q <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      if (capture) begin
        base_q <= base_addr;
      end
      en_q    <= (state_d == WRITE);
      rw_q    <= (state_d != WRITE);
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      busy_q  <= (state_d == WRITE);
      done_q  <= done_d;
    end
  end

  // Block buffer: loaded only on capture, so a start while busy cannot
  // disturb it. Contents after reset are irrelevant, hence no reset.
  always_ff @(posedge clk) begin
    if (capture) begin
      for (int k = 0; k < BLOCK_SIZE; k++) begin
        buf_q[k] <= cap_word[k];
      end
    end
  end

  assign mem.mem_en    = en_q;
  assign mem.mem_rw    = rw_q;
  assign mem.mem_addr  = addr_q;
  assign mem.mem_wdata = wdata_q;
  assign busy          = busy_q;
  assign done          = done_q;

endmodule

// File: tb/tb_dma_block_writer.sv
// tb_dma_block_writer
//   Scoreboard bench for dma_block_writer. Stimulus pushes the expected
//   (address, data) of every word and the expected done cycle; a negedge
//   monitor compares whatever the DUT presents against the queue heads.
module tb_dma_block_writer;

  localparam int AW = 16;
  localparam int DW = 16;
  localparam int BS = 25;
  localparam int BW = BS * DW;

  typedef struct {
    logic [AW-1:0] addr;
    logic [DW-1:0] data;
  } exp_word_t;

  logic          clk;
  logic          rst;
  logic          start;
  logic [AW-1:0] base_addr;
  logic [BW-1:0] block_in;
  logic          busy;
  logic          done;

  dma_block_writer_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) mem_bus ();

  dma_block_writer #(
    .ADDR_WIDTH(AW),
    .DATA_WIDTH(DW),
    .BLOCK_SIZE(BS)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .base_addr (base_addr),
    .block_in  (block_in),
    .busy      (busy),
    .done      (done),
    .mem       (mem_bus.master)
  );

  exp_word_t exp_q[$];
  int        done_q[$];
  exp_word_t mon_word;
  int        cyc = 0;
  int        n_compared = 0;
  int        n_mismatched = 0;

  // Free-running clock, 10 time units per period.
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Edge counter: cyc equals the index of the most recent rising edge.
  always @(posedge clk) cyc <= cyc + 1;

  task automatic checkOutput(input string name, input logic [31:0] act,
                             input logic [31:0] exp);
    n_compared++;
    if (act !== exp) begin
      n_mismatched++;
      $display("[TB] FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)",
               name, act, exp, cyc);
    end
  endtask

  function automatic logic [DW-1:0] modelWord(input logic [DW-1:0] w);
`ifdef DMA_WB_RELU_EN
    return w[DW-1] ? '0 : w;
`else
    return w;
`endif
  endfunction

  function automatic logic [BW-1:0] makeBlock(input logic [DW-1:0] first);
    logic [BW-1:0] b;
    for (int k = 0; k < BS; k++) b[k*DW +: DW] = first + DW'(k);
    return b;
  endfunction

  task automatic waitEdges(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Issues one start (sampled at the next edge, E0), queues the expected
  // words and the expected done cycle E(BS + stalls), then scrambles inputs.
  task automatic applyStimulus(input logic [AW-1:0] base,
                               input logic [BW-1:0] blk,
                               input int stalls);
    exp_word_t e;
    for (int k = 0; k < BS; k++) begin
      e.addr = base + AW'(k);
      e.data = modelWord(blk[k*DW +: DW]);
      exp_q.push_back(e);
    end
    done_q.push_back(cyc + 1 + BS + stalls);
    start     = 1'b1;
    base_addr = base;
    block_in  = blk;
    waitEdges(1);
    start     = 1'b0;
    base_addr = ~base;
    block_in  = ~blk;
  endtask

  task automatic checkResetValues(input string tag);
    checkOutput({tag, "_en"},    {31'd0, mem_bus.mem_en}, 32'd0);
    checkOutput({tag, "_rw"},    {31'd0, mem_bus.mem_rw}, 32'd1);
    checkOutput({tag, "_addr"},  {16'd0, mem_bus.mem_addr}, 32'd0);
    checkOutput({tag, "_wdata"}, {16'd0, mem_bus.mem_wdata}, 32'd0);
    checkOutput({tag, "_busy"},  {31'd0, busy}, 32'd0);
    checkOutput({tag, "_done"},  {31'd0, done}, 32'd0);
  endtask

  // Bounded wait for the outstanding block to complete.
  task automatic waitIdle(input string tag);
    int budget = 0;
    while (done_q.size() != 0 && budget < 200) begin
      @(negedge clk);
      #1;
      budget++;
    end
    waitEdges(1);
    checkOutput({tag, "_timeout"},    done_q.size(), 32'd0);
    checkOutput({tag, "_words_left"}, exp_q.size(), 32'd0);
  endtask

  // Monitor: every presented word must match the queue head; it is popped
  // only when accepted (no stall), so a stall re-checks the same entry.
  always @(negedge clk) begin
    if (!rst && mem_bus.mem_en === 1'b1) begin
      checkOutput("rw_on_write", {31'd0, mem_bus.mem_rw}, 32'd0);
      if (exp_q.size() == 0) begin
        checkOutput("unexpected_write", {16'd0, mem_bus.mem_addr}, 32'hFFFF_FFFF);
      end else begin
        mon_word = exp_q[0];
        checkOutput("wr_addr",  {16'd0, mem_bus.mem_addr},  {16'd0, mon_word.addr});
        checkOutput("wr_wdata", {16'd0, mem_bus.mem_wdata}, {16'd0, mon_word.data});
        if (mem_bus.mem_wait === 1'b0) void'(exp_q.pop_front());
      end
    end
    if (!rst && done === 1'b1) begin
      if (done_q.size() == 0) begin
        checkOutput("unexpected_done", 32'd1, 32'd0);
      end else begin
        checkOutput("done_cycle", cyc, done_q.pop_front());
      end
    end
  end

  logic [BW-1:0] relu_blk;

  initial begin
    rst              = 1'b1;
    start            = 1'b0;
    base_addr        = '0;
    block_in         = '0;
    mem_bus.mem_wait = 1'b0;
    waitEdges(2);
    checkResetValues("reset");
    rst = 1'b0;
    waitEdges(1);

    $display("[TB] plain block, base 0x0100");
    applyStimulus(16'h0100, makeBlock(16'h0400), 0);
    waitIdle("plain");

    $display("[TB] 3-cycle stall on word 10");
    applyStimulus(16'h0100, makeBlock(16'h0400), 3);
    waitEdges(10);
    mem_bus.mem_wait = 1'b1;
    waitEdges(3);
    mem_bus.mem_wait = 1'b0;
    waitIdle("stall");

    $display("[TB] address wrap from 0xFFF0");
    applyStimulus(16'hFFF0, makeBlock(16'h1000), 0);
    waitIdle("wrap");

    $display("[TB] start while busy, then start in done cycle");
    applyStimulus(16'h0200, makeBlock(16'h0600), 0);
    waitEdges(4);
    start     = 1'b1;
    base_addr = 16'h3000;
    block_in  = makeBlock(16'h7700);
    waitEdges(1);
    start = 1'b0;
    checkOutput("busy_mid", {31'd0, busy}, 32'd1);
    waitEdges(20);
    checkOutput("done_pulse", {31'd0, done}, 32'd1);
    applyStimulus(16'h0300, makeBlock(16'h0500), 0);
    checkOutput("b2b_en",   {31'd0, mem_bus.mem_en}, 32'd1);
    checkOutput("b2b_addr", {16'd0, mem_bus.mem_addr}, 32'h0300);
    waitIdle("b2b");

    $display("[TB] reset mid-block after E12");
    applyStimulus(16'h0100, makeBlock(16'h0400), 0);
    waitEdges(12);
    rst = 1'b1;
    waitEdges(1);
    checkResetValues("midrst");
    checkOutput("midrst_pending", exp_q.size(), 32'd13);
    exp_q.delete();
    done_q.delete();
    rst = 1'b0;
    waitEdges(30);
    applyStimulus(16'h0100, makeBlock(16'h0400), 0);
    checkOutput("restart_addr",  {16'd0, mem_bus.mem_addr},  32'h0100);
    checkOutput("restart_wdata", {16'd0, mem_bus.mem_wdata}, 32'h0400);
    waitIdle("restart");

    $display("[TB] negative word handling");
    relu_blk = makeBlock(16'h0200);
    relu_blk[3*DW +: DW] = 16'hF000;
    relu_blk[4*DW +: DW] = 16'h0800;
    applyStimulus(16'h0400, relu_blk, 0);
    waitIdle("relu");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_compared, n_mismatched);
    $finish;
  end

endmodule
